register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port integer register file for the core datapath; successor to the fixed 32x32, 2-read/1-write register file.
- Provides NREAD registered read ports and two write ports with byte enables.
- Register 0 is hardwired to zero.
- Read-during-write is selectable: old-data (BYPASS=0) or forwarded new data (BYPASS=1).

Parameters:
- XLEN, 32, register width in bits; must be a multiple of 8.
- NREG, 32, number of registers; must be a power of two, at least 2.
- NREAD, 2, number of read ports, 1..4.
- BYPASS, 0, 0 = reads return the pre-write value; 1 = same-cycle writes are forwarded to read outputs.
- AW, $clog2(NREG), address width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- write_en  in  2  per-write-port enable; bit w belongs to write port w
- dst_addr  in  2*AW  write addresses; port w occupies [w*AW +: AW]
- dst_data  in  2*XLEN  write data; port w occupies [w*XLEN +: XLEN]
- dst_be  in  2*(XLEN/8)  byte enables per write port
- src_en  in  NREAD  per-read-port sample enable
- src_addr  in  NREAD*AW  read addresses, packed by port
- src_data  out  NREAD*XLEN  registered read data, packed by port
- conflict  out  1  registered flag: both write ports hit the same nonzero address with overlapping byte enables

Behaviour:
- Reset (reset_n low, asynchronous):
  - all NREG entries cleared to 0;
  - all src_data cleared to 0;
  - conflict cleared to 0.
  - Reset asserted mid-operation overrides any write or read in that cycle.
  - On deassertion, the first rising edge operates normally.
- Writes, committed at the rising edge:
  - For each port w with write_en[w]=1 and dst_addr nonzero: byte b of entry dst_addr takes dst_data byte b where dst_be bit b=1; other bytes hold.
  - Writes to address 0 are discarded; entry 0 always reads 0.
  - write_en=1 with dst_be all zero is a no-op.
- Dual-write collision:
  - Both ports hit the same address: port 1 wins for overlapping bytes.
  - Non-overlapping bytes from each port are both written.
  - conflict is set to 1 on the following cycle only if bytes overlap and the address is nonzero; otherwise conflict=0.
- Reads (registered, 1-cycle latency):
  - At the rising edge, if src_en[r]=1, src_data[r] takes the value of entry src_addr[r]; if src_en[r]=0, src_data[r] holds.
  - The value is visible after the edge.
  - BYPASS=0: the sampled value is the entry contents before this edge's writes. A read and a write to the same register in one cycle returns the old value; the new value appears on the next read.
  - BYPASS=1: the sampled value is the post-write merge. Bytes written this cycle (port 1 over port 0) replace the stored bytes.
  - Address 0 always yields 0 in both modes.
- Multiple read ports may address the same entry; all return identical data.
- Address inputs are exactly AW bits; no out-of-range case exists.
- No combinational path from any input to any output.

Test Plan:
- Reset, then read r0 and r1 on ports 0 and 1 -> src_data = 0,0. Then write_en=01, addr 0, data FFFFFFFF, be=F; read addr 0 -> 0.
- Write r1=00000001, r2=00000002 via port 0, then read (1,2) -> 1,2. Write r5=AAAAAAAA (port 0) and r6=55555555 (port 1) in the same cycle; read (5,6) -> AAAAAAAA,55555555, conflict=0.
- Same-cycle read r1 and write r1=3:
  - BYPASS=0 -> returns 1; the next read returns 3.
  - BYPASS=1 -> returns 3 immediately.
- Collision: r4=00000000; port 0 writes r4=11111111 be=0011; port 1 writes r4=22222222 be=0110 -> r4=00222211, conflict=1 for one cycle. Disjoint be -> conflict=0.
- src_en hold: read r2 (value 2), drop src_en[0], write r2=9, change addr -> src_data[0] stays 2. Re-enable -> 9.
- Async reset mid-stream: assert reset_n=0 between clock edges -> src_data and conflict go to 0 immediately. After release, read (1,2) -> 0,0.

Source files
------------

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: write/read port bundle for the multi-port register file
interface register_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREG)
) ();
    logic [1:0]            write_en;
    logic [2*AW-1:0]       dst_addr;
    logic [2*XLEN-1:0]     dst_data;
    logic [2*(XLEN/8)-1:0] dst_be;
    logic [NREAD-1:0]      src_en;
    logic [NREAD*AW-1:0]   src_addr;
    logic [NREAD*XLEN-1:0] src_data;
    logic                  conflict;

    modport master (
        output write_en, dst_addr, dst_data, dst_be, src_en, src_addr,
        input  src_data, conflict
    );

    modport slave (
        input  write_en, dst_addr, dst_data, dst_be, src_en, src_addr,
        output src_data, conflict
    );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: NREAD registered read ports, two byte-enabled write ports, r0 hardwired to zero
module register_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 0,
    parameter int AW     = $clog2(NREG)
) (
    input logic clk,
    input logic reset_n,
    register_file_mp_if.slave bus
);
    localparam int NB = XLEN / 8;

    if (XLEN % 8 != 0 || NREG < 2 || (NREG & (NREG - 1)) != 0 || NREAD < 1 || NREAD > 4)
        $error("register_file_mp: illegal parameter combination");

    logic [XLEN-1:0]       mem_q [NREG];
    logic [XLEN-1:0]       mem_d [NREG];
    logic [NREAD*XLEN-1:0] src_data_q, src_data_d;
    logic                  conflict_q, conflict_d;
    logic [AW-1:0]         a0, a1;

    assign a0 = bus.dst_addr[AW-1:0];
    assign a1 = bus.dst_addr[2*AW-1:AW];

    // Merge both write ports into the next array image; port 1 is applied last so it wins on overlap
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < 2; w++)
            if (bus.write_en[w] && bus.dst_addr[w*AW +: AW] != '0)
                for (int b = 0; b < NB; b++)
                    if (bus.dst_be[w*NB + b])
                        mem_d[bus.dst_addr[w*AW +: AW]][b*8 +: 8] = bus.dst_data[w*XLEN + b*8 +: 8];
        mem_d[0] = '0;
    end

    // Read ports sample either the pre-write or the merged image; disabled ports hold
    always_comb begin
        src_data_d = src_data_q;
        for (int r = 0; r < NREAD; r++)
            if (bus.src_en[r])
                src_data_d[r*XLEN +: XLEN] = (BYPASS != 0) ? mem_d[bus.src_addr[r*AW +: AW]]
                                                           : mem_q[bus.src_addr[r*AW +: AW]];
    end

    // Flag overlapping byte writes from both ports to the same live register
    always_comb begin
        conflict_d = (&bus.write_en) && (a0 == a1) && (a0 != '0) &&
                     (|(bus.dst_be[NB-1:0] & bus.dst_be[2*NB-1:NB]));
    end

    // State update; reset clears the array and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q      <= '{default: '0};
            src_data_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            src_data_q <= src_data_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.src_data = src_data_q;
    assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench driving old-data and bypass instances in lockstep
module tb_register_file_mp;
    typedef struct {
        string        name;
        logic [129:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vec = 0;
    int   err = 0;
    exp_t exp_q[$];

    register_file_mp_if bus0 ();
    register_file_mp_if bus1 ();

    assign bus1.write_en = bus0.write_en;
    assign bus1.dst_addr = bus0.dst_addr;
    assign bus1.dst_data = bus0.dst_data;
    assign bus1.dst_be   = bus0.dst_be;
    assign bus1.src_en   = bus0.src_en;
    assign bus1.src_addr = bus0.src_addr;

    register_file_mp #(.BYPASS(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    register_file_mp #(.BYPASS(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    always #5 clk = ~clk;

    function automatic logic [129:0] obs();
        return {bus0.src_data[31:0], bus0.src_data[63:32],
                bus1.src_data[31:0], bus1.src_data[63:32], bus0.conflict, bus1.conflict};
    endfunction

    function automatic void push(string n, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] c, logic [31:0] d, logic cf);
        exp_t e;
        e.name = n;
        e.v = {a, b, c, d, cf, cf};
        exp_q.push_back(e);
    endfunction

    task automatic wr(int p, logic [4:0] a, logic [31:0] d, logic [3:0] be);
        bus0.write_en[p] = 1'b1;
        bus0.dst_addr[p*5 +: 5] = a;
        bus0.dst_data[p*32 +: 32] = d;
        bus0.dst_be[p*4 +: 4] = be;
    endtask

    task automatic rd(int p, logic [4:0] a);
        bus0.src_en[p] = 1'b1;
        bus0.src_addr[p*5 +: 5] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus0.write_en = '0;
        bus0.src_en = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        bus0.write_en = '0; bus0.dst_addr = '0; bus0.dst_data = '0; bus0.dst_be = '0;
        bus0.src_en = '0; bus0.src_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push("reset_state", 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        rd(0, 0); rd(1, 1);
        push("reset_read", 0, 0, 0, 0, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        wr(0, 0, 32'hFFFF_FFFF, 4'hF); rd(0, 0); rd(1, 0);
        push("r0_write_same_cycle", 0, 0, 0, 0, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        rd(0, 0); rd(1, 0);
        push("r0_after_write", 0, 0, 0, 0, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_basic();
        exp_t e;
        wr(0, 1, 32'h1, 4'hF); tick();
        wr(0, 2, 32'h2, 4'hF); tick();
        rd(0, 1); rd(1, 2);
        push("read_1_2", 1, 2, 1, 2, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        wr(0, 5, 32'hAAAA_AAAA, 4'hF); wr(1, 6, 32'h5555_5555, 4'hF);
        tick();
        rd(0, 5); rd(1, 6);
        push("dual_write_5_6", 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_rdw();
        exp_t e;
        wr(0, 1, 32'h3, 4'hF); rd(0, 1); rd(1, 1);
        push("rdw_same_cycle", 1, 1, 3, 3, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        rd(0, 1); rd(1, 1);
        push("rdw_next_read", 3, 3, 3, 3, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_collision();
        exp_t e;
        wr(0, 4, 32'h0, 4'hF); tick();
        wr(0, 4, 32'h1111_1111, 4'b0011); wr(1, 4, 32'h2222_2222, 4'b0110);
        rd(0, 4); rd(1, 4);
        push("overlap_write", 0, 0, 32'h0022_2211, 32'h0022_2211, 1);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        push("conflict_one_cycle", 0, 0, 32'h0022_2211, 32'h0022_2211, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        wr(0, 4, 32'hAAAA_AAAA, 4'b0011); wr(1, 4, 32'hBBBB_BBBB, 4'b1100);
        rd(0, 4); rd(1, 4);
        push("disjoint_write", 32'h0022_2211, 32'h0022_2211, 32'hBBBB_AAAA, 32'hBBBB_AAAA, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        wr(0, 0, 32'h1234_5678, 4'hF); wr(1, 0, 32'h8765_4321, 4'hF);
        rd(0, 4); rd(1, 0);
        push("overlap_addr0", 32'hBBBB_AAAA, 0, 32'hBBBB_AAAA, 0, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        wr(0, 4, 32'hFFFF_FFFF, 4'h0); rd(0, 4);
        push("zero_be_noop", 32'hBBBB_AAAA, 0, 32'hBBBB_AAAA, 0, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_hold();
        exp_t e;
        rd(0, 2); rd(1, 2);
        push("hold_prime", 2, 2, 2, 2, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        bus0.src_addr[4:0] = 5'd5;
        wr(0, 2, 32'h9, 4'hF); rd(1, 2);
        push("hold_disabled", 2, 2, 2, 9, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        rd(0, 2);
        push("hold_reenable", 9, 2, 9, 9, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        wr(0, 3, 32'h7, 4'hF); wr(1, 3, 32'h8, 4'h1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        push("async_reset_immediate", 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd(0, 1); rd(1, 2);
        push("after_reset_read", 0, 0, 0, 0, 0);
        tick();
        e = exp_q.pop_front(); vec++;
        if (obs() !== e.v) begin err++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            logic [4:0]  a;
            logic [31:0] prev;
            a = 5'(8 + i);
            prev = (i == 0) ? 32'h0 : 32'hC0DE_0000 + 32'(i - 1);
            wr(0, a, 32'hC0DE_0000 + 32'(i), 4'hF);
            rd(0, (i == 0) ? 5'd0 : a - 5'd1);
            rd(1, a);
            push("back_to_back", prev, 0, prev, 32'hC0DE_0000 + 32'(i), 0);
            tick();
            e = exp_q.pop_front(); vec++;
            if (obs() !== e.v) begin err++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, obs(), e.v); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rdw();
        test_collision();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
